rv32_mem_interconnect: RTL and testbench

- Shares one synchronous single-port memory between the instruction fetch port and the load/store port of a multi-cycle RV32 core.
- Provides request/ready handshakes on both ports, fixed or round-robin arbitration, address-range decode with error response, byte-lane writes and a configurable number of memory wait states.
- Sits between the core and the unified memory in the system top.

---
 rtl/rv32_mem_pkg.sv | 17 +
 rtl/rv32_mem_arbiter.sv | 43 ++++
 rtl/rv32_mem_interconnect.sv | 137 +++++++++++++
 tb/tb_rv32_mem_interconnect.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 instruction/data memory interconnect.
// Round-robin arbitration is selected elsewhere by defining RV32_MEM_RR_ARB_EN.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic MID_I = 1'b0;
  localparam logic MID_D = 1'b1;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/rv32_mem_arbiter.sv
// Two-master grant logic for the shared memory port.
// Fixed data-over-fetch priority by default; RV32_MEM_RR_ARB_EN adds a round-robin pointer.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
(
`ifdef RV32_MEM_RR_ARB_EN
  input  logic clk,
  input  logic reset_n,
  input  logic i_grant_en,
`endif
  input  logic i_i_req,
  input  logic i_d_req,
  output logic o_grant_valid,
  output logic o_grant_id
);

  assign o_grant_valid = i_i_req | i_d_req;

`ifdef RV32_MEM_RR_ARB_EN
  logic r_prio_d;

  // After every grant the loser of that grant becomes the preferred master.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio_d <= 1'b1;
    end else if (i_grant_en && o_grant_valid) begin
      r_prio_d <= (o_grant_id == MID_I);
    end
  end

  always_comb begin
    o_grant_id = MID_I;
    if (i_i_req && i_d_req) begin
      o_grant_id = r_prio_d ? MID_D : MID_I;
    end else if (i_d_req) begin
      o_grant_id = MID_D;
    end
  end
`else
  assign o_grant_id = i_d_req ? MID_D : MID_I;
`endif

endmodule

// File: rtl/rv32_mem_interconnect.sv
// Shares one synchronous single-port memory between the fetch and load/store ports.
// Define RV32_MEM_RR_ARB_EN for round-robin arbitration instead of fixed data priority.
module rv32_mem_interconnect
  import rv32_mem_pkg::*;
#(
  parameter int unsigned     AW          = 32,
  parameter int unsigned     DW          = 32,
  parameter logic [AW-1:0]   MEM_BASE    = '0,
  parameter longint unsigned MEM_SIZE    = 4096,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ready,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ready,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            m_en,
  output logic [DW/8-1:0] m_we,
  output logic [AW-3:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam logic [AW:0]             MEM_SIZE_EXT = (AW+1)'(MEM_SIZE);
  localparam logic [WAIT_CNT_W-1:0]   WAIT_LOAD    = WAIT_CNT_W'(WAIT_STATES);

  state_t                r_state;
  logic                  r_id;
  logic                  r_we;
  logic                  r_err;
  logic [DW/8-1:0]       r_be;
  logic [DW-1:0]         r_wdata;
  logic [DW-1:0]         r_rdata;
  logic [AW-3:0]         r_maddr;
  logic [WAIT_CNT_W-1:0] r_cnt;

  logic                  w_idle;
  logic                  w_gvalid;
  logic                  w_gid;
  logic [AW-1:0]         w_addr;
  logic [AW-1:0]         w_off;
  logic                  w_borrow;
  logic                  w_in_range;
  logic                  w_misal;
  logic                  w_err;

  assign w_idle = (r_state == IDLE);

  rv32_mem_arbiter u_arb (
`ifdef RV32_MEM_RR_ARB_EN
    .clk           (clk),
    .reset_n       (reset_n),
    .i_grant_en    (w_idle),
`endif
    .i_i_req       (i_req),
    .i_d_req       (d_req),
    .o_grant_valid (w_gvalid),
    .o_grant_id    (w_gid)
  );

  // Offset computed one bit wider so an address below MEM_BASE shows up as a borrow
  // rather than wrapping into the window.
  assign w_addr                = (w_gid == MID_D) ? d_addr : i_addr;
  assign {w_borrow, w_off}     = {1'b0, w_addr} - {1'b0, MEM_BASE};
  assign w_in_range            = !w_borrow && ({1'b0, w_off} < MEM_SIZE_EXT);
  assign w_misal               = (w_gid == MID_I) && (w_addr[1:0] != 2'b00);
  assign w_err                 = !w_in_range || w_misal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_id    <= MID_D;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_maddr <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gvalid) begin
            r_id    <= w_gid;
            r_we    <= (w_gid == MID_D) && d_we;
            r_be    <= (w_gid == MID_D) ? d_be : '0;
            r_wdata <= (w_gid == MID_D) ? d_wdata : '0;
            r_maddr <= w_off[AW-1:2];
            r_err   <= w_err;
            r_rdata <= '0;
            r_state <= w_err ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          r_cnt   <= WAIT_LOAD;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= r_we ? '0 : m_rdata;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_ready = (r_state == RESP) && (r_id == MID_I);
  assign i_err   = i_ready && r_err;
  assign i_rdata = i_ready ? r_rdata : '0;

  assign d_ready = (r_state == RESP) && (r_id == MID_D);
  assign d_err   = d_ready && r_err;
  assign d_rdata = d_ready ? r_rdata : '0;

  assign m_en    = (r_state == ACCESS);
  assign m_we    = (m_en && r_we) ? r_be : '0;
  assign m_addr  = r_maddr;
  assign m_wdata = r_wdata;

endmodule

// File: tb/tb_rv32_mem_interconnect.sv
// Self-checking bench: instance A has no wait states, instance B has three.
// Grant-order expectations follow RV32_MEM_RR_ARB_EN when it is defined.
module tb_rv32_mem_interconnect;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  logic        a_i_req, a_i_ready, a_i_err, a_d_req, a_d_we, a_d_ready, a_d_err, a_m_en;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_m_wdata, a_m_rdata;
  logic [3:0]  a_d_be, a_m_we;
  logic [29:0] a_m_addr;
  logic        b_i_req, b_i_ready, b_i_err, b_d_req, b_d_we, b_d_ready, b_d_err, b_m_en;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_m_wdata, b_m_rdata;
  logic [3:0]  b_d_be, b_m_we;
  logic [29:0] b_m_addr;

  rv32_mem_interconnect #(.AW(32), .DW(32), .MEM_BASE(32'h0000_1000), .MEM_SIZE(4096), .WAIT_STATES(0)) u_a (
    .clk(clk), .reset_n(rst_n),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready), .i_rdata(a_i_rdata), .i_err(a_i_err),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ready(a_d_ready), .d_rdata(a_d_rdata), .d_err(a_d_err),
    .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata)
  );

  rv32_mem_interconnect #(.AW(32), .DW(32), .MEM_BASE(32'h0000_1000), .MEM_SIZE(4096), .WAIT_STATES(3)) u_b (
    .clk(clk), .reset_n(rst_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata), .i_err(b_i_err),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rdata(b_d_rdata), .d_err(b_d_err),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: A returns data one edge after m_en, B three edges later (garbage before).
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] b_pend;
  int          b_dly;

  always @(posedge clk) begin
    if (a_m_en) begin
      a_m_rdata <= mem_a[a_m_addr[9:0]];
      for (int k = 0; k < 4; k++)
        if (a_m_we[k]) mem_a[a_m_addr[9:0]][8*k +: 8] <= a_m_wdata[8*k +: 8];
    end
  end

  always @(posedge clk) begin
    if (b_m_en) begin
      b_pend    <= mem_b[b_m_addr[9:0]];
      b_m_rdata <= 32'hBAAD_F00D;
      b_dly     <= 3;
      for (int k = 0; k < 4; k++)
        if (b_m_we[k]) mem_b[b_m_addr[9:0]][8*k +: 8] <= b_m_wdata[8*k +: 8];
    end else if (b_dly != 0) begin
      b_dly <= b_dly - 1;
      if (b_dly == 1) b_m_rdata <= b_pend;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  // Monitors sampled on the falling edge.
  int          a_en_cnt, a_we_cnt, a_ir_cnt, a_dr_cnt, b_en_cnt, b_dr_cnt;
  logic [29:0] a_last_maddr;
  logic [3:0]  a_last_we;
  logic [31:0] a_last_wdata;
  int          gl[$];
  int          gcyc[$];
  logic [2:0]  w_prev, w_pend, w_rq, w_rd;

  always @(negedge clk) begin
    if (a_m_en) begin a_en_cnt++; a_last_maddr = a_m_addr; end
    if (a_m_we != 4'h0) begin a_we_cnt++; a_last_we = a_m_we; a_last_wdata = a_m_wdata; end
    if (a_i_ready) begin a_ir_cnt++; gl.push_back(0); gcyc.push_back(cyc); end
    if (a_d_ready) begin a_dr_cnt++; gl.push_back(1); gcyc.push_back(cyc); end
    if (b_m_en) b_en_cnt++;
    if (b_d_ready) b_dr_cnt++;
  end

  // A request may only be withdrawn once its ready pulse has been seen.
  always @(negedge clk) begin
    w_rq = {b_d_req, a_d_req, a_i_req};
    w_rd = {b_d_ready, a_d_ready, a_i_ready};
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        w_pend[k] = 1'b0;
      end else begin
        if (w_rd[k]) w_pend[k] = 1'b0;
        if (w_prev[k] && !w_rq[k]) chk("req_withdrawn_early", {31'b0, w_pend[k]}, 32'd0);
        if (!w_prev[k] && w_rq[k]) w_pend[k] = 1'b1;
      end
    end
    w_prev = w_rq;
  end

  task automatic drive(input int inst, input logic is_d, input logic req, input logic we,
                       input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    if (inst == 0) begin
      if (is_d) begin a_d_req = req; a_d_we = we; a_d_be = be; a_d_addr = addr; a_d_wdata = wd; end
      else begin a_i_req = req; a_i_addr = addr; end
    end else begin
      if (is_d) begin b_d_req = req; b_d_we = we; b_d_be = be; b_d_addr = addr; b_d_wdata = wd; end
      else begin b_i_req = req; b_i_addr = addr; end
    end
  endtask

  // Called just after a rising edge; returns in the cycle that shows ready.
  task automatic do_acc(input int inst, input logic is_d, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int          t0;
    logic        got, rdy, erv;
    logic [31:0] rdv;
    drive(inst, is_d, 1'b1, we, be, addr, wd);
    t0 = cyc; got = 1'b0; rd = '0; er = 1'b0; lat = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      case ({inst[0], is_d})
        2'b00:   begin rdy = a_i_ready; rdv = a_i_rdata; erv = a_i_err; end
        2'b01:   begin rdy = a_d_ready; rdv = a_d_rdata; erv = a_d_err; end
        2'b10:   begin rdy = b_i_ready; rdv = b_i_rdata; erv = b_i_err; end
        default: begin rdy = b_d_ready; rdv = b_d_rdata; erv = b_d_err; end
      endcase
      if (rdy) begin got = 1'b1; rd = rdv; er = erv; lat = cyc - t0; end
    end
    drive(inst, is_d, 1'b0, we, be, addr, wd);
    chk("handshake_completed", {31'b0, got}, 32'd1);
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    logic [29:0] exp_maddr;
    int          exp_wec;
    logic [3:0]  exp_we;
  } vec_t;

  function automatic vec_t mk(logic is_d, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] rd, logic err, int lat, int en, logic [29:0] ma,
                              int wec, logic [3:0] wev);
    vec_t v;
    v.is_d = is_d; v.we = we; v.be = be; v.addr = addr; v.wd = wd; v.exp_rd = rd; v.exp_err = err;
    v.exp_lat = lat; v.exp_en = en; v.exp_maddr = ma; v.exp_wec = wec; v.exp_we = wev;
    return v;
  endfunction

  vec_t        vt [17];
  int          exp_ord [8];
  logic [31:0] rd, rdi, rdd;
  logic        er, eri, erd;
  int          lat, lati, latd;
  int          s_en, s_we, s_ir, s_dr, base_en, base_dr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    a_en_cnt = 0; a_we_cnt = 0; a_ir_cnt = 0; a_dr_cnt = 0; b_en_cnt = 0; b_dr_cnt = 0;
    w_prev = '0; w_pend = '0; b_dly = 0; a_m_rdata = '0; b_m_rdata = '0; b_pend = '0;
    a_last_maddr = '0; a_last_we = '0; a_last_wdata = '0;
    for (int k = 0; k < 1024; k++) begin mem_a[k] = '0; mem_b[k] = '0; end
    mem_a[0] = 32'h0000_0013; mem_a[4] = 32'h0050_0093; mem_a[8] = 32'h1122_3344;
    mem_a[1023] = 32'hCAFE_F00D;
    mem_b[5] = 32'h7654_3210; mem_b[7] = 32'hAAAA_5555;
    drive(0, 0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0, 0);

`ifdef RV32_MEM_RR_ARB_EN
    exp_ord = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_ord = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif

    vt[0]  = mk(0, 0, 4'h0, 32'h0000_1010, 32'h0,         32'h0050_0093, 0, 3, 1, 30'd4,    0, 4'h0);
    vt[1]  = mk(1, 1, 4'h3, 32'h0000_1020, 32'hDEAD_BEEF, 32'h0,         0, 3, 1, 30'd8,    1, 4'h3);
    vt[2]  = mk(1, 0, 4'h0, 32'h0000_1020, 32'h0,         32'h1122_BEEF, 0, 3, 1, 30'd8,    0, 4'h0);
    vt[3]  = mk(1, 0, 4'h0, 32'h0000_1022, 32'h0,         32'h1122_BEEF, 0, 3, 1, 30'd8,    0, 4'h0);
    vt[4]  = mk(1, 1, 4'h0, 32'h0000_1020, 32'hFFFF_FFFF, 32'h0,         0, 3, 1, 30'd8,    0, 4'h0);
    vt[5]  = mk(1, 0, 4'h0, 32'h0000_1020, 32'h0,         32'h1122_BEEF, 0, 3, 1, 30'd8,    0, 4'h0);
    vt[6]  = mk(1, 0, 4'h0, 32'h0000_2000, 32'h0,         32'h0,         1, 1, 0, 30'd0,    0, 4'h0);
    vt[7]  = mk(0, 0, 4'h0, 32'h0000_1002, 32'h0,         32'h0,         1, 1, 0, 30'd0,    0, 4'h0);
    vt[8]  = mk(1, 0, 4'h0, 32'h0000_0FFC, 32'h0,         32'h0,         1, 1, 0, 30'd0,    0, 4'h0);
    vt[9]  = mk(0, 0, 4'h0, 32'h0000_1FFC, 32'h0,         32'hCAFE_F00D, 0, 3, 1, 30'd1023, 0, 4'h0);
    vt[10] = mk(1, 0, 4'h0, 32'h0000_1FFF, 32'h0,         32'hCAFE_F00D, 0, 3, 1, 30'd1023, 0, 4'h0);
    vt[11] = mk(1, 1, 4'hC, 32'h0000_1024, 32'hA5A5_5A5A, 32'h0,         0, 3, 1, 30'd9,    1, 4'hC);
    vt[12] = mk(1, 0, 4'h0, 32'h0000_1024, 32'h0,         32'hA5A5_0000, 0, 3, 1, 30'd9,    0, 4'h0);
    vt[13] = mk(0, 0, 4'h0, 32'hFFFF_F000, 32'h0,         32'h0,         1, 1, 0, 30'd0,    0, 4'h0);
    vt[14] = mk(0, 0, 4'h0, 32'h0000_1FFE, 32'h0,         32'h0,         1, 1, 0, 30'd0,    0, 4'h0);
    vt[15] = mk(1, 1, 4'hF, 32'h0000_2000, 32'h1234_5678, 32'h0,         1, 1, 0, 30'd0,    0, 4'h0);
    vt[16] = mk(0, 0, 4'h0, 32'h0000_1000, 32'h0,         32'h0000_0013, 0, 3, 1, 30'd0,    0, 4'h0);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'b0, a_i_ready, a_i_err, a_d_ready, a_d_err, a_m_en}, 32'd0);
    chk("rst_m_we", {28'b0, a_m_we}, 32'd0);
    chk("rst_m_addr", {2'b0, a_m_addr}, 32'd0);
    chk("rst_m_wdata", a_m_wdata, 32'd0);
    chk("rst_rdata", a_i_rdata | a_d_rdata | b_i_rdata | b_d_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      s_en = a_en_cnt; s_we = a_we_cnt; s_ir = a_ir_cnt; s_dr = a_dr_cnt;
      do_acc(0, vt[i].is_d, vt[i].we, vt[i].be, vt[i].addr, vt[i].wd, rd, er, lat);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_m_en_pulses", i), a_en_cnt - s_en, vt[i].exp_en);
      chk($sformatf("v%0d_m_we_cycles", i), a_we_cnt - s_we, vt[i].exp_wec);
      chk($sformatf("v%0d_own_ready", i), vt[i].is_d ? a_dr_cnt - s_dr : a_ir_cnt - s_ir, 32'd1);
      chk($sformatf("v%0d_other_ready", i), vt[i].is_d ? a_ir_cnt - s_ir : a_dr_cnt - s_dr, 32'd0);
      if (vt[i].exp_en > 0) chk($sformatf("v%0d_m_addr", i), {2'b0, a_last_maddr}, {2'b0, vt[i].exp_maddr});
      if (vt[i].exp_wec > 0) begin
        chk($sformatf("v%0d_m_we", i), {28'b0, a_last_we}, {28'b0, vt[i].exp_we});
        chk($sformatf("v%0d_m_wdata", i), a_last_wdata, vt[i].wd);
      end
    end

    // Both masters contend for four transactions each.
    gl.delete(); gcyc.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          do_acc(0, 0, 0, 4'h0, 32'h0000_1010, 32'h0, rdi, eri, lati);
          chk("cont_i_rdata", rdi, 32'h0050_0093);
          @(posedge clk); #1;
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          do_acc(0, 1, 0, 4'h0, 32'h0000_1010, 32'h0, rdd, erd, latd);
          chk("cont_d_rdata", rdd, 32'h0050_0093);
          @(posedge clk); #1;
        end
      end
    join
    chk("cont_grant_count", gl.size(), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("cont_grant%0d_id", k), (k < gl.size()) ? gl[k] : -1, exp_ord[k]);
      if (k > 0) chk($sformatf("cont_gap%0d", k), (k < gcyc.size()) ? gcyc[k] - gcyc[k-1] : -1, 32'd4);
    end

    // Three wait states on instance B.
    base_en = b_en_cnt;
    do_acc(1, 1, 0, 4'h0, 32'h0000_1014, 32'h0, rd, er, lat);
    chk("ws3_load_rdata", rd, 32'h7654_3210);
    chk("ws3_load_latency", lat, 32'd6);
    chk("ws3_load_err", {31'b0, er}, 32'd0);
    @(posedge clk); #1;
    chk("ws3_load_m_en", b_en_cnt - base_en, 32'd1);
    do_acc(1, 0, 0, 4'h0, 32'h0000_1014, 32'h0, rd, er, lat);
    chk("ws3_fetch_rdata", rd, 32'h7654_3210);
    chk("ws3_fetch_latency", lat, 32'd6);
    @(posedge clk); #1;
    do_acc(1, 1, 0, 4'h0, 32'h0000_2004, 32'h0, rd, er, lat);
    chk("ws3_err_latency", lat, 32'd1);
    chk("ws3_err_flag", {31'b0, er}, 32'd1);
    @(posedge clk); #1;

    // Reset while a store sits in WAIT: the write already happened, nothing is re-issued.
    drive(1, 1, 1'b1, 1'b1, 4'hF, 32'h0000_1018, 32'h1234_5678);
    @(posedge clk); #1;
    chk("rstw_access_m_en", {31'b0, b_m_en}, 32'd1);
    @(posedge clk); #1;
    chk("rstw_wait_m_en", {31'b0, b_m_en}, 32'd0);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_m_ctrl", {23'b0, b_m_en, b_m_we, b_d_ready, b_d_err, b_i_ready, b_i_err}, 32'd0);
    chk("rstw_m_addr", {2'b0, b_m_addr}, 32'd0);
    chk("rstw_m_wdata", b_m_wdata, 32'd0);
    chk("rstw_d_rdata", b_d_rdata, 32'd0);
    drive(1, 1, 1'b0, 1'b1, 4'hF, 32'h0000_1018, 32'h1234_5678);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base_en = b_en_cnt; base_dr = b_dr_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("rstw_no_reissue", b_en_cnt - base_en, 32'd0);
    chk("rstw_no_ready", b_dr_cnt - base_dr, 32'd0);
    do_acc(1, 1, 0, 4'h0, 32'h0000_1018, 32'h0, rd, er, lat);
    chk("rstw_readback", rd, 32'h1234_5678);
    chk("rstw_readback_latency", lat, 32'd6);
    @(posedge clk); #1;

    // Reset during ACCESS: enables drop at once and the store never lands.
    drive(1, 1, 1'b1, 1'b1, 4'hF, 32'h0000_101C, 32'h0F0F_0F0F);
    @(posedge clk); #1;
    chk("rsta_m_en_before", {31'b0, b_m_en}, 32'd1);
    chk("rsta_m_we_before", {28'b0, b_m_we}, 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("rsta_m_en_after", {31'b0, b_m_en}, 32'd0);
    chk("rsta_m_we_after", {28'b0, b_m_we}, 32'd0);
    drive(1, 1, 1'b0, 1'b1, 4'hF, 32'h0000_101C, 32'h0F0F_0F0F);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base_en = b_en_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("rsta_no_reissue", b_en_cnt - base_en, 32'd0);
    do_acc(1, 1, 0, 4'h0, 32'h0000_101C, 32'h0, rd, er, lat);
    chk("rsta_readback", rd, 32'hAAAA_5555);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
